// File: rtl/sense_reader.sv
// Delay-line sensor reader: on trigger, settles the sensor, captures DEPTH
// popcount samples of the thermometer code, then drains them over a valid/ready port.
module sense_reader #(
  parameter int LINELEN = 64,
  parameter int DEPTH   = 256,
  parameter int SETTLE  = 2
) (
  input  logic               clkin,
  input  logic               rstnin,
  input  logic [LINELEN-1:0] valin,
  input  logic               trigin,
  output logic               enaout,
  output logic [7:0]         dataout,
  output logic               validout,
  input  logic               readyin,
  output logic               busyout,
  output logic               missout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (AW + 1 > 4) ? AW + 1 : 4;
  localparam int PW = $clog2(LINELEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          load;
  logic [PW-1:0] pc;
  logic [7:0]    sample;
  logic [7:0]    mem [DEPTH];

  // Full popcount so bubbles in the thermometer code are still counted.
  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < LINELEN; i++) begin
      pc = pc + PW'(valin[i]);
    end
    if (32'(pc) > 32'd255) sample = '1;
    else                   sample = 8'(pc);
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      ST_IDLE:    if (trigin) state_n = ST_SETTLE;
      ST_SETTLE:  if (cnt == CW'(SETTLE - 1)) state_n = ST_CAPTURE;
      ST_CAPTURE: if (cnt == CW'(DEPTH - 1)) state_n = ST_DRAIN;
      ST_DRAIN: begin
        // Output register is free when empty or being taken this edge.
        if (!validout || readyin) begin
          if (cnt != CW'(DEPTH)) load = 1'b1;
          else                   state_n = ST_IDLE;
        end
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      missout  <= 1'b0;
      dataout  <= '0;
      validout <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (state == ST_SETTLE || state == ST_CAPTURE || load)
        cnt <= cnt + CW'(1);
      if (trigin && state != ST_IDLE)
        missout <= 1'b1;
      if (load) begin
        dataout  <= mem[cnt[AW-1:0]];
        validout <= 1'b1;
      end else if (state_n != ST_DRAIN) begin
        validout <= 1'b0;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (state == ST_CAPTURE)
      mem[cnt[AW-1:0]] <= sample;
  end

  assign enaout  = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign busyout = (state != ST_IDLE);

endmodule

// File: tb/tb_sense_reader.sv
// Scoreboard bench for sense_reader: DEPTH=8, SETTLE=2, LINELEN=64.
module tb_sense_reader;

  localparam int LINELEN = 64;
  localparam int DEPTH   = 8;
  localparam int SETTLE  = 2;
  localparam int K_RAMP  = 0;
  localparam int K_FULL  = 1;
  localparam int K_RAND  = 2;

  logic               clkin = 1'b0;
  logic               rstnin;
  logic [LINELEN-1:0] valin;
  logic               trigin;
  logic               enaout;
  logic [7:0]         dataout;
  logic               validout;
  logic               readyin = 1'b1;
  logic               busyout;
  logic               missout;

  int     checks = 0;
  int     errors = 0;
  int     en_cnt = 0;
  bit     bp = 1'b0;
  int     bi = 0;
  logic [7:0] q[$];
  logic   pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  sense_reader #(.LINELEN(LINELEN), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clkin   (clkin),
    .rstnin  (rstnin),
    .valin   (valin),
    .trigin  (trigin),
    .enaout  (enaout),
    .dataout (dataout),
    .validout(validout),
    .readyin (readyin),
    .busyout (busyout),
    .missout (missout)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clkin) begin
    readyin = bp ? pat[bi % 4] : 1'b1;
    bi++;
  end

  // Output monitor: a transfer is pending for the next rising edge.
  always @(negedge clkin) begin
    #1;
    if (rstnin) begin
      if (pv && !pr) begin
        chk("hold_valid", validout, 1'b1);
        chk("hold_data", dataout, pd);
      end
      if (validout && readyin) begin
        if (q.size() == 0) chk("extra_xfer", validout, 1'b0);
        else               chk("data", dataout, q.pop_front());
      end
      if (enaout) en_cnt++;
    end
    pv = validout;
    pr = readyin;
    pd = dataout;
  end

  function automatic logic [LINELEN-1:0] pattern(input int kind, input int k);
    logic [LINELEN-1:0] v;
    logic [LINELEN-1:0] one;
    one = 1;
    case (kind)
      K_RAMP:  v = (one << k) - one;
      K_FULL:  v = (k < 4) ? '1 : 64'h00FF00FF00FF00FF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Called just after a falling edge; returns at the last capture edge.
  task automatic capture(input int kind, input bit pulse, input bit hold);
    trigin = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    if (!hold) trigin = 1'b0;
    chk("busy_settle", busyout, 1'b1);
    @(posedge clkin);
    @(posedge clkin);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clkin);
      valin = pattern(kind, k);
      q.push_back(8'($countones(valin)));
      if (pulse && k == 3) trigin = 1'b1;
      else if (!hold)      trigin = 1'b0;
      @(posedge clkin);
    end
  endtask

  task automatic wait_idle(input int exp_en);
    int n;
    n = 0;
    while ((busyout || q.size() != 0) && n < 300) begin
      @(negedge clkin);
      n++;
    end
    #2;
    chk("drain_in_time", (n < 300), 1'b1);
    chk("queue_empty", q.size(), 0);
    chk("valid_idle", validout, 1'b0);
    chk("enaout_cycles", en_cnt, exp_en);
    en_cnt = 0;
  endtask

  initial begin
    rstnin = 1'b0;
    trigin = 1'b0;
    valin  = '0;
    #12;
    chk("rst_enaout", enaout, 1'b0);
    chk("rst_validout", validout, 1'b0);
    chk("rst_busyout", busyout, 1'b0);
    chk("rst_missout", missout, 1'b0);
    chk("rst_dataout", dataout, 8'd0);
    @(negedge clkin);
    rstnin = 1'b1;

    capture(K_RAMP, 1'b0, 1'b0);
    wait_idle(SETTLE + DEPTH);
    chk("miss_clean", missout, 1'b0);

    @(negedge clkin);
    capture(K_FULL, 1'b0, 1'b0);
    wait_idle(SETTLE + DEPTH);

    @(negedge clkin);
    bp = 1'b1;
    capture(K_RAND, 1'b0, 1'b0);
    wait_idle(SETTLE + DEPTH);
    bp = 1'b0;

    @(negedge clkin);
    capture(K_RAMP, 1'b1, 1'b0);
    repeat (3) @(negedge clkin);
    trigin = 1'b1;
    @(negedge clkin);
    trigin = 1'b0;
    wait_idle(SETTLE + DEPTH);
    repeat (2) @(negedge clkin);
    chk("miss_sticky", missout, 1'b1);

    // Reset in the middle of a capture.
    trigin = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    trigin = 1'b0;
    repeat (5) @(negedge clkin);
    rstnin = 1'b0;
    #1;
    chk("arst_enaout", enaout, 1'b0);
    chk("arst_busyout", busyout, 1'b0);
    chk("arst_validout", validout, 1'b0);
    chk("arst_missout", missout, 1'b0);
    q.delete();
    @(negedge clkin);
    rstnin = 1'b1;
    en_cnt = 0;
    capture(K_RAMP, 1'b0, 1'b0);
    wait_idle(SETTLE + DEPTH);

    // Held trigger: back-to-back captures, 20 edges apart with readyin=1.
    @(negedge clkin);
    capture(K_RAND, 1'b0, 1'b1);
    repeat (9) @(posedge clkin);
    @(negedge clkin);
    chk("held_idle_gap", busyout, 1'b0);
    chk("held_q_empty", q.size(), 0);
    chk("held_en_cycles", en_cnt, SETTLE + DEPTH);
    en_cnt = 0;
    capture(K_RAMP, 1'b0, 1'b1);
    @(negedge clkin);
    trigin = 1'b0;
    wait_idle(SETTLE + DEPTH);
    chk("held_missout", missout, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sense_reader.md
SENSE_READER -- requirements
Module: sense_reader

Interface
REQ-001 SHALL have parameter LINELEN, default 64, width of the thermometer code taken from the delay-line sensor.
REQ-002 SHALL have parameter DEPTH, default 256, number of samples per capture (power of two, 2..1024).
REQ-003 SHALL have parameter SETTLE, default 2, number of cycles with enaout high before the first sample is stored (1..15).
REQ-004 SHALL have port clkin  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rstnin  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valin  input  LINELEN  thermometer code from the sensor output register.
REQ-007 SHALL have port trigin  input  1  capture request, level-sampled.
REQ-008 SHALL have port enaout  output  1  drives the sensor enable input.
REQ-009 SHALL have port dataout  output  8  sample byte.
REQ-010 SHALL have port validout  output  1  dataout holds a valid sample.
REQ-011 SHALL have port readyin  input  1  downstream accepts dataout.
REQ-012 SHALL have port busyout  output  1  high in any state other than IDLE.
REQ-013 SHALL have port missout  output  1  sticky flag: a trigger was dropped.

Function
REQ-014 SHALL implement states IDLE, SETTLE, CAPTURE and DRAIN.
REQ-015 In IDLE with trigin=1 at an edge, SHALL enter SETTLE; enaout SHALL be 1 from that edge until DRAIN is entered.
REQ-016 SHALL remain in SETTLE for exactly SETTLE cycles, store nothing, then enter CAPTURE.
REQ-017 In CAPTURE, SHALL store one sample per cycle, DEPTH consecutive cycles, addresses 0..DEPTH-1 in order, with no gaps.
REQ-018 Sample value SHALL be the popcount of valin (number of ones, 0..LINELEN), zero-extended to 8 bits; a value above 255 SHALL saturate to 255.
REQ-019 Popcount SHALL count every one bit of valin, so non-monotonic codes (bubbles) still yield the total number of ones.
REQ-020 Sampling of valin MAY be pipelined, but stored sample k SHALL equal popcount of valin at CAPTURE cycle k.
REQ-021 After the DEPTH-th store, SHALL enter DRAIN and set enaout to 0.
REQ-022 In DRAIN, SHALL present samples 0..DEPTH-1 in order on dataout with validout=1; a transfer occurs on an edge with validout=1 and readyin=1.
REQ-023 While validout=1 and readyin=0, dataout and validout SHALL hold stable.
REQ-024 With readyin held at 1, SHALL sustain one transfer per cycle after the first one; the first validout SHALL appear within 2 cycles of entering DRAIN.
REQ-025 After sample DEPTH-1 transfers, SHALL deassert validout on the next edge and return to IDLE.
REQ-026 A new trigger SHALL be accepted no earlier than the cycle after IDLE is re-entered.
REQ-027 trigin=1 at an edge while busyout=1 SHALL be ignored and SHALL set missout to 1; missout SHALL clear only on reset.
REQ-028 validout SHALL be 0 in IDLE, SETTLE and CAPTURE.
REQ-029 busyout SHALL be 1 from the edge leaving IDLE through the edge returning to IDLE.

Reset
REQ-030 rstnin=0 SHALL immediately force IDLE, enaout=0, validout=0, busyout=0, missout=0 and dataout=0, regardless of state.
REQ-031 Buffer contents need not be cleared on reset, and a reset mid-capture or mid-drain SHALL discard the capture.
REQ-032 After rstnin deasserts, trigin SHALL be honoured from the first rising edge.

Verification
REQ-033 Capture with DEPTH=8, SETTLE=2, valin ramped to k ones on capture cycle k, readyin=1 -> enaout high for exactly 10 cycles; dataout sequence 0,1,...,7.
REQ-034 valin=all ones (64) throughout, then valin=64'h00FF00FF00FF00FF -> samples 64, then 32.
REQ-035 Backpressure: readyin toggles 1,0,0,1 during DRAIN -> no sample lost or duplicated; dataout is stable while readyin=0.
REQ-036 Pulse trigin during CAPTURE and during DRAIN -> capture unaffected; missout=1, which stays 1 after returning to IDLE.
REQ-037 Assert rstnin=0 mid-CAPTURE for 1 cycle -> enaout, busyout, validout and missout go to 0 asynchronously; the next trigin starts a fresh full capture.
REQ-038 Hold trigin=1 continuously -> back-to-back captures, each DEPTH samples; the second SETTLE starts the cycle after IDLE is re-entered; missout is set by the held trigger during busy.
